// File: rtl/collision_tracker.sv
// collision_tracker: per-frame collision detector for the multi-player snake game.
// Accumulates head-overlap evidence per player during the active scan and
// publishes one registered 2-bit result code per player at frame end, held
// behind a valid/ack handshake.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   frame_start         pulse at start of a frame's active area
//   frame_end           pulse after the last active pixel
//   pixel_valid         current pixel is in the active area
//   border_active       pixel is border
//   apple_active        pixel is apple
//   head_active[N]      pixel is player i's head
//   body_active[N]      pixel is player i's body
//   result_ack          consumer accepts the current result
//   state_o[2N]         per-player code: 00 reset, 01 collision, 10 apple, 11 clear
//   result_valid        state_o holds an unconsumed result
//   collision_any       OR of all collision codes, registered with state_o
//   overrun             sticky: a result was discarded unacknowledged
//
// Optional build macro: HEAD_ON_EN - head-to-head overlap also counts as a hit
// for every player involved.
module collision_tracker #(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MIN_OVERLAP = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   pixel_valid,
  input  logic                   border_active,
  input  logic                   apple_active,
  input  logic [N_PLAYERS-1:0]   head_active,
  input  logic [N_PLAYERS-1:0]   body_active,
  input  logic                   result_ack,
  output logic [2*N_PLAYERS-1:0] state_o,
  output logic                   result_valid,
  output logic                   collision_any,
  output logic                   overrun
);

  localparam int unsigned      SW         = 2 * N_PLAYERS;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MIN_THR    = CNT_W'(MIN_OVERLAP);
  localparam logic [1:0]       CODE_COLL  = 2'b01;
  localparam logic [1:0]       CODE_APPLE = 2'b10;
  localparam logic [1:0]       CODE_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } fsm_e;

  fsm_e                             fsm_q, fsm_d;
  logic [N_PLAYERS-1:0][CNT_W-1:0]  coll_cnt_q, coll_cnt_d;
  logic [N_PLAYERS-1:0]             apple_flag_q, apple_flag_d;
  logic [SW-1:0]                    code_q, code_d;
  logic                             valid_q, valid_d;
  logic                             any_q, any_d;
  logic                             overrun_q, overrun_d;

  logic [N_PLAYERS-1:0]             hit;
  logic [N_PLAYERS-1:0][CNT_W-1:0]  cnt_pix;
  logic [N_PLAYERS-1:0]             apple_pix;
  logic [SW-1:0]                    report_code;
  logic                             report_any;

  // Per-player hit detection and the counter/flag values after this pixel.
  always_comb begin
    hit       = '0;
    cnt_pix   = coll_cnt_q;
    apple_pix = apple_flag_q;
    for (int i = 0; i < N_PLAYERS; i++) begin
      hit[i] = head_active[i] & (border_active | (|body_active));
`ifdef HEAD_ON_EN
      hit[i] = hit[i] | (head_active[i] &
                         (|(head_active & ~(N_PLAYERS'(1) << i))));
`endif
      if (pixel_valid) begin
        if (hit[i] && (coll_cnt_q[i] != CNT_MAX)) begin
          cnt_pix[i] = coll_cnt_q[i] + CNT_W'(1);
        end
        if (head_active[i] && apple_active) begin
          apple_pix[i] = 1'b1;
        end
      end
    end
  end

  // Verdict built from the post-pixel values so a frame_end pixel still counts.
  always_comb begin
    report_code = '0;
    report_any  = 1'b0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (cnt_pix[i] >= MIN_THR) begin
        report_code[2*i +: 2] = CODE_COLL;
        report_any            = 1'b1;
      end else if (apple_pix[i]) begin
        report_code[2*i +: 2] = CODE_APPLE;
      end else begin
        report_code[2*i +: 2] = CODE_CLEAR;
      end
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    fsm_d        = fsm_q;
    coll_cnt_d   = coll_cnt_q;
    apple_flag_d = apple_flag_q;
    code_d       = code_q;
    valid_d      = valid_q;
    any_d        = any_q;
    overrun_d    = overrun_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (frame_start) begin
          fsm_d        = ST_SCAN;
          coll_cnt_d   = '0;
          apple_flag_d = '0;
        end
      end
      ST_SCAN: begin
        coll_cnt_d   = cnt_pix;
        apple_flag_d = apple_pix;
        if (frame_end) begin
          fsm_d   = ST_REPORT;
          code_d  = report_code;
          any_d   = report_any;
          valid_d = 1'b1;
        end else if (frame_start) begin
          coll_cnt_d   = '0;
          apple_flag_d = '0;
        end
      end
      ST_REPORT: begin
        if (result_ack) begin
          valid_d = 1'b0;
          if (frame_start) begin
            fsm_d        = ST_SCAN;
            coll_cnt_d   = '0;
            apple_flag_d = '0;
          end else begin
            fsm_d = ST_IDLE;
          end
        end else if (frame_start) begin
          // Unconsumed verdict is dropped; state_o keeps its last value.
          overrun_d    = 1'b1;
          valid_d      = 1'b0;
          fsm_d        = ST_SCAN;
          coll_cnt_d   = '0;
          apple_flag_d = '0;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= ST_IDLE;
      coll_cnt_q   <= '0;
      apple_flag_q <= '0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      any_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      coll_cnt_q   <= coll_cnt_d;
      apple_flag_q <= apple_flag_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      any_q        <= any_d;
      overrun_q    <= overrun_d;
    end
  end

  assign state_o       = code_q;
  assign result_valid  = valid_q;
  assign collision_any = any_q;
  assign overrun       = overrun_q;

endmodule
